// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus interface: funct3 codes,
// bus SIZE encodings, controller states and the load/access helpers.
package dmem_pkg;

    // RISC-V load/store funct3 codes (stores share the signed codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bus SIZE encodings
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Widest data path the extension helper supports; callers slice down.
    localparam int EXT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Sign/zero-extend the returned bus data according to the load type.
    function automatic logic [EXT_W-1:0] load_extend(input logic [2:0]       funct3,
                                                      input logic [EXT_W-1:0] data);
        logic [EXT_W-1:0] r;
        case (funct3)
            F3_B:    r = {{(EXT_W-8){data[7]}}, data[7:0]};
            F3_H:    r = {{(EXT_W-16){data[15]}}, data[15:0]};
            F3_W:    r = data;
            F3_BU:   r = {{(EXT_W-8){1'b0}}, data[7:0]};
            F3_HU:   r = {{(EXT_W-16){1'b0}}, data[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // True when the access must be answered with an error and no bus cycle:
    // unsupported funct3 for the direction, or a misaligned half/word.
    function automatic logic access_error(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic bad_f3;
        logic misaligned;
        if (we) begin
            bad_f3 = (funct3 > F3_W);
        end else begin
            bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        misaligned = ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && addr_lo[0]);
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// Memory-stage request/response channel plus the bus control signals.
// The bidirectional data line DDT is a resolved net and stays a plain
// inout port on the block so it can join the board-level bus directly.
interface dmem_bus_if_if #(
    parameter int BIT_WIDTH = 32
);
    // memory-stage side
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [BIT_WIDTH-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;
    logic                 resp_valid;
    logic [BIT_WIDTH-1:0] resp_rdata;
    logic                 resp_err;

    // external bus control
    logic [BIT_WIDTH-1:0] DAD;
    logic                 MREQ;
    logic                 WRITE;
    logic [1:0]           SIZE;
    logic                 ACKD_n;

    // Environment view: issues requests and plays the memory on the bus.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ACKD_n,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  DAD, MREQ, WRITE, SIZE
    );

    // Interface-block view.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ACKD_n,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output DAD, MREQ, WRITE, SIZE
    );
endinterface

// File: rtl/dmem_store_align.sv
// Maps funct3/store data to the right-aligned DDT drive value and the bus
// SIZE code. Also used for loads, where only SIZE matters.
module dmem_store_align
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [2:0]           funct3,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] ddt_drive,
    output logic [1:0]           size
);

    // Narrow accesses zero the unused upper lanes.
    always_comb begin
        ddt_drive = wdata;
        size      = SZ_WORD;
        case (funct3)
            F3_B, F3_BU: begin
                ddt_drive = {{(BIT_WIDTH-8){1'b0}}, wdata[7:0]};
                size      = SZ_BYTE;
            end
            F3_H, F3_HU: begin
                ddt_drive = {{(BIT_WIDTH-16){1'b0}}, wdata[15:0]};
                size      = SZ_HALF;
            end
            default: begin
                ddt_drive = wdata;
                size      = SZ_WORD;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: accepts one load/store at a time, runs the
// MREQ/ACKD_n handshake, drives or releases DDT, and returns extended load
// data. Illegal accesses and time-outs answer with resp_err and no bus
// cycle is kept open. All bus outputs are registers with async reset, so
// reset drops MREQ/WRITE and releases DDT immediately.
module dmem_bus_if
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH = 32,   // must not exceed EXT_W
    parameter int TIMEOUT   = 16    // >= 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_bus_if_if.slave         bus,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2:0]           funct3_reg;
    logic                 we_reg;
    logic [BIT_WIDTH-1:0] dad_reg;
    logic [BIT_WIDTH-1:0] ddt_reg;
    logic                 ddt_oe_reg;
    logic                 mreq_reg;
    logic                 write_reg;
    logic [1:0]           size_reg;
    logic [BIT_WIDTH-1:0] rdata_reg;
    logic                 err_reg;

    logic                 req_err;
    logic                 ack;
    logic                 timeout_hit;
    logic                 req_ready;
    logic                 resp_valid;
    logic [BIT_WIDTH-1:0] align_ddt;
    logic [1:0]           align_size;
    logic [EXT_W-1:0]     ext_full;
    logic [BIT_WIDTH-1:0] load_data;
    logic                 unused_ext;

    dmem_store_align #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_align (
        .funct3    (bus.req_funct3),
        .wdata     (bus.req_wdata),
        .ddt_drive (align_ddt),
        .size      (align_size)
    );

    assign req_err     = access_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign ack         = ~bus.ACKD_n;
    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign ext_full    = load_extend(funct3_reg, EXT_W'(DDT));
    assign load_data   = ext_full[BIT_WIDTH-1:0];
    assign unused_ext  = ^ext_full[EXT_W-1:BIT_WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: illegal requests skip the bus; ack wins over time-out.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_next = req_err ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (ack || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state alone.
    always_comb begin
        req_ready  = (state_reg == ST_IDLE);
        resp_valid = (state_reg == ST_RESP);
    end

    // Request capture, bus drive registers, time-out counter and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            funct3_reg <= '0;
            we_reg     <= 1'b0;
            dad_reg    <= '0;
            ddt_reg    <= '0;
            ddt_oe_reg <= 1'b0;
            mreq_reg   <= 1'b0;
            write_reg  <= 1'b0;
            size_reg   <= SZ_WORD;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        funct3_reg <= bus.req_funct3;
                        we_reg     <= bus.req_we;
                        cnt_reg    <= '0;
                        rdata_reg  <= '0;
                        if (req_err) begin
                            err_reg <= 1'b1;
                        end else begin
                            err_reg    <= 1'b0;
                            dad_reg    <= bus.req_addr;
                            size_reg   <= align_size;
                            write_reg  <= bus.req_we;
                            mreq_reg   <= 1'b1;
                            ddt_reg    <= align_ddt;
                            ddt_oe_reg <= bus.req_we;
                        end
                    end
                end
                ST_BUS: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (ack || timeout_hit) begin
                        mreq_reg   <= 1'b0;
                        write_reg  <= 1'b0;
                        ddt_oe_reg <= 1'b0;
                        err_reg    <= ~ack;
                        rdata_reg  <= (ack && !we_reg) ? load_data : '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;
    assign bus.DAD        = dad_reg;
    assign bus.MREQ       = mreq_reg;
    assign bus.WRITE      = write_reg;
    assign bus.SIZE       = size_reg;
    assign DDT            = ddt_oe_reg ? ddt_reg : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: a table of directed load/store
// vectors plus hand-written sequences for time-out, ack stuck low in IDLE,
// and reset during a store cycle.
module tb_dmem_bus_if;

    localparam int W  = 32;
    localparam int TO = 16;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_data;
        int          ack_dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ddt;
        logic [1:0]  exp_size;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] tb_ddt_val;
    logic        tb_ddt_en;
    wire  [31:0] ddt;
    int          n_pass;
    int          n_total;
    vec_t        vecs[$];

    dmem_bus_if_if #(.BIT_WIDTH(W)) bus ();

    assign ddt = tb_ddt_en ? tb_ddt_val : 32'bz;

    dmem_bus_if #(
        .BIT_WIDTH (W),
        .TIMEOUT   (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .DDT   (ddt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // DDT released: a weak-free zero from the bench must read back unchanged.
    task automatic chk_released(input string nm);
        tb_ddt_val = 32'h0;
        tb_ddt_en  = 1'b1;
        #1;
        chk(nm, ddt, 32'h0);
        tb_ddt_en  = 1'b0;
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] bus_data, input int dly,
                                input logic err, input logic [31:0] rdata,
                                input logic [31:0] exp_ddt, input logic [1:0] sz);
        vec_t v;
        v.name = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.bus_data = bus_data; v.ack_dly = dly; v.exp_err = err;
        v.exp_rdata = rdata; v.exp_ddt = exp_ddt; v.exp_size = sz;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk({v.name, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.exp_err) begin
            chk({v.name, " err resp"}, 32'({bus.resp_valid, bus.resp_err, bus.MREQ}), 32'b110);
            chk({v.name, " err rdata"}, bus.resp_rdata, 32'h0);
        end else begin
            chk({v.name, " bus ctl"}, 32'({bus.MREQ, bus.WRITE, bus.SIZE, bus.resp_valid}),
                32'({1'b1, v.we, v.exp_size, 1'b0}));
            chk({v.name, " dad"}, bus.DAD, v.addr);
            if (v.we) chk({v.name, " ddt drive"}, ddt, v.exp_ddt);
            for (int c = 1; c < v.ack_dly; c++) begin
                @(negedge clk);
                chk({v.name, " wait"}, 32'({bus.MREQ, bus.resp_valid}), 32'b10);
            end
            bus.ACKD_n = 1'b0;
            if (!v.we) begin
                tb_ddt_val = v.bus_data;
                tb_ddt_en  = 1'b1;
            end
            @(negedge clk);
            bus.ACKD_n = 1'b1;
            tb_ddt_en  = 1'b0;
            chk({v.name, " resp"}, 32'({bus.resp_valid, bus.resp_err, bus.MREQ, bus.WRITE}), 32'b1000);
            chk({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
            chk_released({v.name, " ddt release"});
        end
        @(negedge clk);
        chk({v.name, " back idle"}, 32'({bus.resp_valid, bus.req_ready, bus.MREQ}), 32'b010);
        $display("txn %-10s we=%0d f3=%03b addr=%08h rdata=%08h err=%0d",
                 v.name, v.we, v.f3, v.addr, v.exp_rdata, v.exp_err);
    endtask

    initial begin
        int mreq_cycles;
        logic got_resp;

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        tb_ddt_en = 1'b0;
        tb_ddt_val = '0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.ACKD_n = 1'b1;

        //           name        we f3      addr          wdata         bus data      dly err rdata         ddt           size
        vecs.push_back(mk("lw",       0, 3'b010, 32'h0800_0010, 32'h0,         32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 32'h0,         2'b00));
        vecs.push_back(mk("lb",       0, 3'b000, 32'h0800_0003, 32'h0,         32'h0000_0080, 1, 0, 32'hFFFF_FF80, 32'h0,         2'b10));
        vecs.push_back(mk("lbu",      0, 3'b100, 32'h0800_0003, 32'h0,         32'h0000_0080, 1, 0, 32'h0000_0080, 32'h0,         2'b10));
        vecs.push_back(mk("lh",       0, 3'b001, 32'h0800_0002, 32'h0,         32'h0000_8001, 1, 0, 32'hFFFF_8001, 32'h0,         2'b01));
        vecs.push_back(mk("lhu",      0, 3'b101, 32'h0800_0002, 32'h0,         32'h0000_8001, 1, 0, 32'h0000_8001, 32'h0,         2'b01));
        vecs.push_back(mk("lbu_hi",   0, 3'b100, 32'h0800_0001, 32'h0,         32'hABCD_12F0, 1, 0, 32'h0000_00F0, 32'h0,         2'b10));
        vecs.push_back(mk("lh_pos",   0, 3'b001, 32'h0800_0006, 32'h0,         32'h1234_7FFE, 2, 0, 32'h0000_7FFE, 32'h0,         2'b01));
        vecs.push_back(mk("lb_pos",   0, 3'b000, 32'h0800_0000, 32'h0,         32'hFFFF_FF7F, 1, 0, 32'h0000_007F, 32'h0,         2'b10));
        vecs.push_back(mk("sb",       1, 3'b000, 32'hF000_0000, 32'h1234_5641, 32'h0,         1, 0, 32'h0,         32'h0000_0041, 2'b10));
        vecs.push_back(mk("sh",       1, 3'b001, 32'hF000_0002, 32'h1234_5641, 32'h0,         1, 0, 32'h0,         32'h0000_5641, 2'b01));
        vecs.push_back(mk("sw",       1, 3'b010, 32'hF000_0004, 32'hCAFE_F00D, 32'h0,         3, 0, 32'h0,         32'hCAFE_F00D, 2'b00));
        vecs.push_back(mk("lw_mis",   0, 3'b010, 32'h0800_0002, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("lh_mis",   0, 3'b001, 32'h0800_0001, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("sw_mis",   1, 3'b010, 32'hF000_0001, 32'h1,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("sh_mis",   1, 3'b001, 32'hF000_0003, 32'h1,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("ld_f3_011",0, 3'b011, 32'h0800_0000, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("ld_f3_110",0, 3'b110, 32'h0800_0000, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("ld_f3_111",0, 3'b111, 32'h0800_0000, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("st_f3_100",1, 3'b100, 32'hF000_0000, 32'h1,         32'h0,         1, 1, 32'h0,         32'h0,         2'b00));
        vecs.push_back(mk("lw_slow",  0, 3'b010, 32'h0800_000C, 32'h0,         32'h0123_4567, 4, 0, 32'h0123_4567, 32'h0,         2'b00));

        // reset values
        #7;
        chk("rst ready/valid/err", 32'({bus.req_ready, bus.resp_valid, bus.resp_err}), 32'b100);
        chk("rst rdata", bus.resp_rdata, 32'h0);
        chk("rst dad", bus.DAD, 32'h0);
        chk("rst mreq/write/size", 32'({bus.MREQ, bus.WRITE, bus.SIZE}), 32'b0000);
        chk_released("rst ddt");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // time-out: ack never arrives
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0800_0020; bus.ACKD_n = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        mreq_cycles = 0;
        got_resp = 1'b0;
        for (int c = 0; c < TO + 4 && !got_resp; c++) begin
            if (bus.resp_valid) begin
                got_resp = 1'b1;
                chk("timeout resp", 32'({bus.resp_err, bus.MREQ}), 32'b10);
                chk("timeout rdata", bus.resp_rdata, 32'h0);
            end else begin
                if (bus.MREQ) mreq_cycles++;
                @(negedge clk);
            end
        end
        chk("timeout mreq cycles", 32'(mreq_cycles), 32'(TO));
        chk("timeout resp seen", 32'(got_resp), 32'd1);
        @(negedge clk);
        chk("timeout back idle", 32'({bus.resp_valid, bus.req_ready}), 32'b01);
        $display("txn timeout    mreq_cycles=%0d err=1", mreq_cycles);

        // ack stuck low while idle must not start anything
        bus.ACKD_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ack low idle", 32'({bus.MREQ, bus.resp_valid, bus.req_ready}), 32'b001);
        end
        run_vec(mk("lw_acklow", 0, 3'b010, 32'h0800_0040, 32'h0, 32'h1357_9BDF, 1, 0,
                   32'h1357_9BDF, 32'h0, 2'b00));

        // reset during the bus cycle of a store
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'hF000_0008; bus.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstmid mreq before", 32'(bus.MREQ), 32'd1);
        chk("rstmid ddt before", ddt, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid mreq/write", 32'({bus.MREQ, bus.WRITE}), 32'b00);
        chk_released("rstmid ddt");
        chk("rstmid ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid after", 32'({bus.resp_valid, bus.req_ready, bus.MREQ}), 32'b010);
        end
        $display("txn rst_mid_sw addr=f0000008 no response");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
